// File: rtl/sequential_subtractor.sv
`default_nettype none
// ============================================================================
// sequential_subtractor: chunk-serial a - b with borrow chain, start/done handshake
// Revision: 1.0
// ============================================================================
module sequential_subtractor #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] res,
  output logic             borrow,
  output logic             overflow,
  output logic             busy,
  output logic             done
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [WIDTH-1:0] a_op;
  logic [WIDTH-1:0] b_op;
  logic [WIDTH-1:0] acc;
  logic             borrow_chain;
  logic [IDXW-1:0]  idx;

  logic             accept;
  logic             last;
  logic [CHUNK:0]   diff;
  logic [WIDTH+CHUNK-1:0] acc_cat;
  logic [WIDTH-1:0] acc_nxt;
  logic             ovf_nxt;

  // Operands shift right each cycle so chunk idx is always in the low bits;
  // the accumulator fills from the top so chunk idx lands at idx*CHUNK.
  assign diff    = {1'b0, a_op[CHUNK-1:0]} - {1'b0, b_op[CHUNK-1:0]}
                 - {{CHUNK{1'b0}}, borrow_chain};
  assign acc_cat = {diff[CHUNK-1:0], acc};
  assign acc_nxt = acc_cat[WIDTH+CHUNK-1:CHUNK];
  assign ovf_nxt = (a_op[CHUNK-1] != b_op[CHUNK-1]) && (diff[CHUNK-1] != a_op[CHUNK-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last      = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = SUB;
        end
      end
      SUB: begin
        busy = 1'b1;
        if (idx == LAST_IDX) begin
          last      = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          accept    = 1'b1;
          state_nxt = SUB;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_op         <= '0;
      b_op         <= '0;
      acc          <= '0;
      borrow_chain <= 1'b0;
      idx          <= '0;
      res          <= '0;
      borrow       <= 1'b0;
      overflow     <= 1'b0;
    end else if (accept) begin
      a_op         <= a;
      b_op         <= b;
      acc          <= '0;
      borrow_chain <= 1'b0;
      idx          <= '0;
    end else if (busy) begin
      a_op         <= a_op >> CHUNK;
      b_op         <= b_op >> CHUNK;
      acc          <= acc_nxt;
      borrow_chain <= diff[CHUNK];
      idx          <= idx + 1'b1;
      if (last) begin
        res      <= acc_nxt;
        borrow   <= diff[CHUNK];
        overflow <= ovf_nxt;
      end
    end
  end

endmodule
`default_nettype wire
